// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding and lamp patterns for the N-way traffic controller
package traffic_pkg;

   typedef enum logic [1:0] {
      S_ALLRED = 2'd0,
      S_GREEN  = 2'd1,
      S_YELLOW = 2'd2,
      S_FLASH  = 2'd3
   } state_t;

   localparam logic [2:0] LAMP_R   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_G   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/tl_tick_gen.sv
// tl_tick_gen: prescaler producing a one-cycle tick every TICK_DIV clocks, used as a clock enable
module tl_tick_gen #(
   parameter int TICK_DIV = 125000000
) (
   input  logic clk_125M,
   input  logic rst,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick  = cnt_q == CW'(TICK_DIV - 1);
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   // free-running count 0..TICK_DIV-1
   always_ff @(posedge clk_125M or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;

endmodule

// File: rtl/traffic_ctrl_nway.sv
// traffic_ctrl_nway: N-phase round-robin light controller with min/max green; flash mode under TRAFFIC_FLASH_MODE_EN
module traffic_ctrl_nway
   import traffic_pkg::*;
#(
   parameter int NUM_PHASES = 2,
   parameter int TICK_DIV   = 125000000,
   parameter int GREEN_MIN  = 10,
   parameter int GREEN_MAX  = 30,
   parameter int YELLOW_T   = 3,
   parameter int ALLRED_T   = 1,
   parameter int TW         = 8
) (
   input  logic                    clk_125M,
   input  logic                    rst,
   input  logic [NUM_PHASES-1:0]   req,
`ifdef TRAFFIC_FLASH_MODE_EN
   input  logic                    flash,
`endif
   output logic [3*NUM_PHASES-1:0] lights,
   output logic [2:0]              cur_phase,
   output logic [1:0]              state,
   output logic                    tick
);

   state_t                  state_q, state_d;
   logic [2:0]              cur_q, cur_d, nxt_q, nxt_d, sel;
   logic [TW-1:0]           timer_q, timer_d;
   logic [NUM_PHASES-1:0]   pend_q, pend_d;
   logic [3*NUM_PHASES-1:0] lights_q, lights_d;
   logic                    req_cur;
   int                      elapsed;
`ifdef TRAFFIC_FLASH_MODE_EN
   logic                    blink_q, blink_d;
`endif

   tl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk_125M (clk_125M),
      .rst      (rst),
      .tick     (tick)
   );

   assign lights    = lights_q;
   assign cur_phase = cur_q;
   assign state     = state_q;

   // phase sequencing: transitions only on tick, next phase picked round-robin from pending
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      nxt_d   = nxt_q;
      elapsed = int'(timer_q) + 1;
      sel     = '0;
      req_cur = 1'b0;
      for (int o = NUM_PHASES - 1; o >= 1; o--)
         for (int i = 0; i < NUM_PHASES; i++)
            if (pend_q[i] && i == (int'(cur_q) + o) % NUM_PHASES) sel = 3'(i);
      for (int i = 0; i < NUM_PHASES; i++)
         if (cur_q == 3'(i)) req_cur = req[i];
      if (tick)
         case (state_q)
            S_ALLRED: if (elapsed == ALLRED_T) begin
               state_d = S_GREEN;
               cur_d   = nxt_q;
            end
            S_GREEN: if (cur_q == '0 ? (elapsed >= GREEN_MIN && |pend_q)
                                     : ((elapsed >= GREEN_MIN && !req_cur) || elapsed >= GREEN_MAX)) begin
               state_d = S_YELLOW;
               nxt_d   = sel;
            end
            S_YELLOW: if (elapsed == YELLOW_T) state_d = S_ALLRED;
            default: ;
         endcase
`ifdef TRAFFIC_FLASH_MODE_EN
      blink_d = blink_q;
      if (tick && flash) begin
         state_d = S_FLASH;
         cur_d   = cur_q;
         nxt_d   = nxt_q;
         blink_d = (state_q == S_FLASH) ? !blink_q : 1'b1;
      end else if (tick && state_q == S_FLASH) begin
         state_d = S_ALLRED;
         cur_d   = '0;
         nxt_d   = '0;
      end
`endif
   end

   // dwell timer, pending requests and registered lamp pattern
   always_comb begin
      timer_d = (state_d != state_q) ? '0
              : (tick && timer_q != TW'(GREEN_MAX)) ? timer_q + 1'b1 : timer_q;
      for (int i = 0; i < NUM_PHASES; i++) begin
         pend_d[i] = (i == 0) ? 1'b0
                   : ((state_q == S_GREEN && cur_q == 3'(i)) ||
                      (state_d == S_GREEN && state_q != S_GREEN && cur_d == 3'(i))) ? 1'b0
                   : pend_q[i] | req[i];
         lights_d[3*i +: 3] = (cur_d == 3'(i) && state_d == S_GREEN)  ? LAMP_G
                            : (cur_d == 3'(i) && state_d == S_YELLOW) ? LAMP_Y : LAMP_R;
`ifdef TRAFFIC_FLASH_MODE_EN
         if (state_d == S_FLASH) lights_d[3*i +: 3] = !blink_d ? LAMP_OFF : (i == 0) ? LAMP_Y : LAMP_R;
`endif
      end
`ifdef TRAFFIC_FLASH_MODE_EN
      if (state_q == S_FLASH && state_d == S_ALLRED) pend_d = '0;
`endif
   end

   // state registers, asynchronously forced to all-red on reset
   always_ff @(posedge clk_125M or posedge rst)
      if (rst) begin
         state_q  <= S_ALLRED;
         cur_q    <= '0;
         nxt_q    <= '0;
         timer_q  <= '0;
         pend_q   <= '0;
         lights_q <= {NUM_PHASES{LAMP_R}};
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         nxt_q    <= nxt_d;
         timer_q  <= timer_d;
         pend_q   <= pend_d;
         lights_q <= lights_d;
      end

`ifdef TRAFFIC_FLASH_MODE_EN
   // blink phase for flash mode
   always_ff @(posedge clk_125M or posedge rst)
      if (rst) blink_q <= 1'b0;
      else     blink_q <= blink_d;
`endif

endmodule
